// File: rtl/pgm_pkg.sv
// pgm_pkg: shared constants and state encoding for the
// PGM replay scheduler.
package pgm_pkg;

  localparam int PGM_ADDR_W = 7;
  localparam int RAM_W      = 144;
  localparam int GEN_W      = 134;
  localparam int HDR_HI     = 133;
  localparam int HDR_LO     = 132;

  localparam logic [1:0] HDR  = 2'b01;
  localparam logic [1:0] MID  = 2'b11;
  localparam logic [1:0] TAIL = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_GAP   = 3'd4
  } state_t;

endpackage

// File: rtl/pgm_sched_if.sv
// pgm_sched_if: RAM read port plus generator output bus
// of the replay scheduler.
interface pgm_sched_if #(
  parameter int ADDR_W = pgm_pkg::PGM_ADDR_W
);
  import pgm_pkg::*;

  logic              rd2ram_rd_en;
  logic [ADDR_W-1:0] rd2ram_addr;
  logic [RAM_W-1:0]  ram_rdata;
  logic [GEN_W-1:0]  out_gen_data;
  logic              out_gen_data_wr;
  logic              out_gen_valid;
  logic              out_gen_valid_wr;
  logic              in_gen_alf;

  modport master (
    output rd2ram_rd_en,
    output rd2ram_addr,
    input  ram_rdata,
    output out_gen_data,
    output out_gen_data_wr,
    output out_gen_valid,
    output out_gen_valid_wr,
    input  in_gen_alf
  );

  modport slave (
    input  rd2ram_rd_en,
    input  rd2ram_addr,
    output ram_rdata,
    input  out_gen_data,
    input  out_gen_data_wr,
    input  out_gen_valid,
    input  out_gen_valid_wr,
    output in_gen_alf
  );

endinterface

// File: rtl/pgm_gap_cnt.sv
// pgm_gap_cnt: 16-bit loadable down-counter that holds
// at zero; times the idle gap between packets.
module pgm_gap_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        en,
  input  logic [15:0] din,
  output logic [15:0] cnt,
  output logic        zero
);

  assign zero = (cnt == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 16'd0;
    end else if (load) begin
      cnt <= din;
    end else if (en && !zero) begin
      cnt <= cnt - 16'd1;
    end
  end

endmodule

// File: rtl/pgm_sched.sv
// pgm_sched: replays the stored PGM template from the
// packet RAM as bursts with programmable count and gap.
module pgm_sched
  import pgm_pkg::*;
#(
  parameter string PLATFORM = "Xilinx",
  parameter int    ADDR_W   = PGM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr2ram_wr_en,
  input  logic [ADDR_W-1:0] wr2ram_addr,
  input  logic              pgm_sent_start_flag,
  input  logic              pgm_sent_finish_flag,
  input  logic              pgm_bypass_flag,
  input  logic              sched_en,
  input  logic [31:0]       burst_cnt,
  input  logic [15:0]       gap_cycles,
  pgm_sched_if.master       gen,
  output logic [31:0]       sent_pkt_cnt,
  output logic              sched_busy
);

  localparam bit unused_platform = (PLATFORM == "Xilinx");

  state_t            state, nxt;
  logic              start_q, fin_q, en_q, rd_q;
  logic              tpl_ok, stop_req, pend_vld;
  logic [ADDR_W-1:0] last_addr, pend_addr, rd_addr;
  logic [31:0]       pkt_cnt, pkt_inc;
  logic [15:0]       gap_cnt;
  logic              gap_zero, is_idle, start_ok;
  logic              stop_evt, stop_now, burst_done;
  logic              tail_hit, unused_ok;

  assign is_idle  = (state == S_IDLE);
  assign start_ok = pgm_sent_start_flag & ~start_q
                  & sched_en & tpl_ok & ~pgm_bypass_flag;

  // a template rewrite counts as a stop request
  assign stop_evt = (pgm_sent_finish_flag & ~fin_q)
                  | (en_q & ~sched_en)
                  | wr2ram_wr_en;
  assign stop_now = stop_req | stop_evt;

  assign pkt_inc    = (&pkt_cnt) ? pkt_cnt : pkt_cnt + 32'd1;
  assign burst_done = (burst_cnt != 32'd0) && (pkt_inc == burst_cnt);
  assign unused_ok  = &{1'b0, gen.ram_rdata[RAM_W-1:GEN_W]};

  pgm_gap_cnt u_gap (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state == S_DRAIN),
    .en    (state == S_GAP),
    .din   (gap_cycles),
    .cnt   (gap_cnt),
    .zero  (gap_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (start_ok) nxt = S_ARM;
      S_ARM: begin
        if (stop_now)             nxt = S_IDLE;
        else if (!gen.in_gen_alf) nxt = S_READ;
      end
      S_READ:  if (rd_addr == last_addr) nxt = S_DRAIN;
      S_DRAIN: nxt = (stop_now || burst_done) ? S_IDLE : S_GAP;
      S_GAP:   if (gap_zero || gap_cnt == 16'd1) nxt = S_ARM;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q   <= 1'b0;
      fin_q     <= 1'b0;
      en_q      <= 1'b0;
      rd_q      <= 1'b0;
      tpl_ok    <= 1'b0;
      stop_req  <= 1'b0;
      pend_vld  <= 1'b0;
      last_addr <= '0;
      pend_addr <= '0;
      rd_addr   <= '0;
      pkt_cnt   <= 32'd0;
    end else begin
      start_q <= pgm_sent_start_flag;
      fin_q   <= pgm_sent_finish_flag;
      en_q    <= sched_en;
      rd_q    <= (state == S_READ);
      if (is_idle) begin
        if (wr2ram_wr_en) begin
          last_addr <= wr2ram_addr;
          tpl_ok    <= 1'b1;
          pend_vld  <= 1'b0;
        end else if (pend_vld) begin
          last_addr <= pend_addr;
          pend_vld  <= 1'b0;
        end
        if (start_ok) begin
          pkt_cnt  <= 32'd0;
          stop_req <= 1'b0;
        end
      end else begin
        // busy-time writes land in last_addr once back in idle
        if (wr2ram_wr_en) begin
          pend_addr <= wr2ram_addr;
          pend_vld  <= 1'b1;
        end
        if (stop_evt) stop_req <= 1'b1;
      end
      if (state == S_DRAIN) pkt_cnt <= pkt_inc;
      if (state == S_ARM)       rd_addr <= '0;
      else if (state == S_READ) rd_addr <= rd_addr + ADDR_W'(1);
    end
  end

  assign tail_hit = rd_q && (state == S_DRAIN)
                 && (gen.ram_rdata[HDR_HI:HDR_LO] == TAIL);

  always_comb begin
    gen.rd2ram_rd_en     = (state == S_READ);
    gen.rd2ram_addr      = (state == S_READ) ? rd_addr : '0;
    gen.out_gen_data_wr  = rd_q;
    gen.out_gen_data     = rd_q ? gen.ram_rdata[GEN_W-1:0] : '0;
    gen.out_gen_valid    = tail_hit;
    gen.out_gen_valid_wr = tail_hit;
    sched_busy           = !is_idle;
    sent_pkt_cnt         = pkt_cnt;
  end

endmodule

// File: doc/pgm_sched.md
# pgm_sched

Replay scheduler for the PGM packet RAM. Once the PGM writer has stored a template packet and raised its start flag, this block reads the packet back out of the 128×144 RAM. It emits the packet repeatedly on the generator output as a burst with a programmable count and inter-packet gap, honouring downstream almost-full. It sits beside the PGM writer, owns the RAM read port, and feeds the generator datapath towards the next module.

## Interface
- PLATFORM, "Xilinx", target vendor tag
- ADDR_W, 7, PGM RAM address width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- wr2ram_wr_en  in  1  snooped writer RAM write enable
- wr2ram_addr  in  ADDR_W  snooped writer RAM address
- pgm_sent_start_flag  in  1  writer: template stored
- pgm_sent_finish_flag  in  1  writer: stop request
- pgm_bypass_flag  in  1  writer is bypassing a normal packet
- sched_en  in  1  enable replay
- burst_cnt  in  32  packets per burst; 0 = run until finish
- gap_cycles  in  16  idle cycles between packets
- rd2ram_rd_en  out  1  RAM read enable
- rd2ram_addr  out  ADDR_W  RAM read address
- ram_rdata  in  144  RAM read data, 1-cycle latency
- out_gen_data  out  134  generated packet word (ram_rdata[133:0])
- out_gen_data_wr  out  1  word strobe
- out_gen_valid  out  1  packet valid flag
- out_gen_valid_wr  out  1  valid strobe (tail word only)
- in_gen_alf  in  1  downstream almost-full
- sent_pkt_cnt  out  32  packets emitted in the current burst
- sched_busy  out  1  high outside IDLE

## Operation
- last_addr register: loaded with wr2ram_addr on every wr2ram_wr_en while in IDLE. tpl_ok is set on any such write.
- start_evt = rising edge of pgm_sent_start_flag. fin_evt = rising edge of pgm_sent_finish_flag. Both are detected with one registered copy of each flag.
- States: IDLE, ARM, READ, DRAIN, GAP.
- IDLE
  - On start_evt with sched_en=1, tpl_ok=1 and pgm_bypass_flag=0: clear sent_pkt_cnt and stop_req, then go to ARM.
  - Otherwise stay in IDLE.
- ARM: wait while in_gen_alf=1. When in_gen_alf=0, go to READ with rd_addr=0.
  - in_gen_alf is sampled only at packet start. A packet is never stalled mid-flight.
- READ
  - Assert rd2ram_rd_en, rd2ram_addr=rd_addr, increment rd_addr.
  - When rd_addr==last_addr is issued, go to DRAIN.
- Output stage: one cycle after each read, out_gen_data=ram_rdata[133:0] and out_gen_data_wr=1.
- DRAIN: emit the final word. If ram_rdata[133:132]==2'b10, also set out_gen_valid=1 and out_gen_valid_wr=1. Then:
  - increment sent_pkt_cnt, saturating at 32'hFFFF_FFFF;
  - if stop_req, or burst_cnt!=0 and the new count equals burst_cnt, go to IDLE;
  - else go to GAP, loading the gap counter with gap_cycles.
- GAP: decrement the counter. When it reaches 0 (or is 0 on entry), go to ARM.
- fin_evt in any non-IDLE state sets stop_req. The current packet completes and the block then returns to IDLE. No partial packet is ever emitted.
- sched_en falling outside IDLE is treated as fin_evt.
- A writer write (wr2ram_wr_en=1) outside IDLE also sets stop_req, because the template is being replaced. last_addr does not update until IDLE.
- A start_evt while not in IDLE is ignored.

## Timing
- Reset values: all outputs 0. Internal state: IDLE, last_addr=0, tpl_ok=0, stop_req=0.
- Reset is asynchronous. Asserting it mid-packet drops outputs to 0 immediately. The truncated packet is not repaired.
- start_evt at cycle T (flag first seen high):
  - ARM at T+1;
  - first read at T+2 if alf=0;
  - head word at T+3.
- A packet of N=last_addr+1 words occupies N consecutive out_gen_data_wr cycles.
- Tail at cycle E: the next head appears at E+gap_cycles+3 at the earliest (GAP, ARM, read latency), and later if alf is high.
- out_gen_valid and out_gen_valid_wr are pulses of one cycle. out_gen_data is zeroed on cycles without a strobe.
- Simultaneous fin_evt and DRAIN: the packet counts, and the next state is IDLE.

## Structure
- Shared package pgm_pkg holds:
  - state localparams;
  - header codes HDR=2'b01, MID=2'b11, TAIL=2'b10;
  - field position 133:132;
  - RAM width 144 and ADDR_W.
- Sub-module pgm_gap_cnt: 16-bit loadable down-counter with load, enable and zero outputs. It is instantiated once.

## Test plan
- Template of 4 words, burst_cnt=3, gap_cycles=5, alf=0 -> 3 packets of 4 words:
  - heads 0x01 tag, tail with valid_wr;
  - tail-to-head spacing of 8 cycles;
  - sent_pkt_cnt ends at 3, then IDLE.
- burst_cnt=0, then pulse finish mid-packet 2 -> packet 2 completes, sent_pkt_cnt=2, no third head.
- in_gen_alf held high 20 cycles in ARM -> no rd_en for 20 cycles; alf is ignored when raised mid-packet (all words still emitted back-to-back).
- start_evt with pgm_bypass_flag=1 or sched_en=0 or tpl_ok=0 -> stays IDLE, no strobes.
- Writer write during GAP -> current burst stops at ARM→IDLE boundary; next start uses the new last_addr.
- rst_n low mid-packet word 2 -> all outputs 0 the same cycle; after release, IDLE with sent_pkt_cnt=0.
